// File: rtl/ethernet_pkg.sv
// Shared Ethernet TX constants plus beat/byte-enable helpers for the 64-bit AXI-Stream path.
package ethernet_pkg;

    localparam int ARP_FRAME_BYTES = 54;
    localparam int AXIS_DATA_W     = 64;
    localparam int AXIS_KEEP_W     = 8;
    localparam logic [63:0] PREAMBLE_SFD = 64'h55555555555555D5;

    typedef logic [ARP_FRAME_BYTES*8-1:0] arp_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    // Frame byte j lives at the MSB end of the vector; beat k lane n carries frame byte 8k+n.
    function automatic logic [AXIS_DATA_W-1:0] beat_of(input arp_frame_t frame, input int k);
        logic [AXIS_DATA_W-1:0] beat;
        int j;
        beat = '0;
        for (int n = 0; n < AXIS_KEEP_W; n++) begin
            j = k * AXIS_KEEP_W + n;
            if (j < ARP_FRAME_BYTES) begin
                beat[8*n +: 8] = frame[(ARP_FRAME_BYTES - j)*8 - 1 -: 8];
            end
        end
        return beat;
    endfunction

    function automatic logic [AXIS_KEEP_W-1:0] keep_of(input int k);
        logic [AXIS_KEEP_W-1:0] keep;
        keep = '0;
        for (int n = 0; n < AXIS_KEEP_W; n++) begin
            if (k * AXIS_KEEP_W + n < ARP_FRAME_BYTES) begin
                keep[n] = 1'b1;
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/ethernet_arp_reply_serializer.sv
// Serializes a 54-byte ARP reply frame into 7 AXI-Stream beats, with one pending slot and an idle gap.
// Latency: strobe at cycle N gives beat 0 at N+1; next frame starts IFG_CYCLES+1 cycles after last handshake.
// Backpressure: i_tready low holds the beat indefinitely; a third frame while active+pending is dropped.
module ethernet_arp_reply_serializer
    import ethernet_pkg::*;
#(
    parameter int FRAME_BYTES = ARP_FRAME_BYTES,
    parameter int DATA_W      = AXIS_DATA_W,
    parameter int IFG_CYCLES  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [FRAME_BYTES*8-1:0] i_arp_reply,
    input  logic                     i_arp_reply_ready,
    output logic [DATA_W-1:0]        o_tdata,
    output logic [DATA_W/8-1:0]      o_tkeep,
    output logic                     o_tvalid,
    output logic                     o_tlast,
    input  logic                     i_tready,
    output logic                     o_busy,
    output logic                     o_drop
);

    localparam int BEATS  = (FRAME_BYTES + DATA_W/8 - 1) / (DATA_W/8);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int IFG_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    tx_state_e                r_state;
    tx_state_e                w_state_nxt;
    logic [FRAME_BYTES*8-1:0] r_active;
    logic [FRAME_BYTES*8-1:0] r_pending;
    logic                     r_pend_vld;
    logic [BEAT_W-1:0]        r_beat;
    logic [IFG_W-1:0]         r_ifg;
    logic                     r_drop;

    logic w_hs;
    logic w_last_hs;
    logic w_release;
    logic w_promote;
    logic w_load_new;
    logic w_to_pend;
    logic w_drop;

    // w_release marks the cycle the gap is satisfied; a strobe then may go straight to active.
    assign w_hs       = (r_state == ST_SEND) && i_tready;
    assign w_last_hs  = w_hs && (r_beat == LAST_BEAT);
    assign w_release  = ((r_state == ST_GAP) && (r_ifg == IFG_LAST)) ||
                        (w_last_hs && (IFG_CYCLES == 0));
    assign w_promote  = w_release && r_pend_vld;
    assign w_load_new = i_arp_reply_ready && !r_pend_vld &&
                        ((r_state == ST_IDLE) || w_release);
    assign w_to_pend  = i_arp_reply_ready && !w_load_new && (!r_pend_vld || w_promote);
    assign w_drop     = i_arp_reply_ready && !w_load_new && !w_to_pend;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_load_new) w_state_nxt = ST_SEND;
            ST_SEND: if (w_last_hs)  w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_GAP;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_release) begin
            w_state_nxt = (w_promote || w_load_new) ? ST_SEND : ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active   <= '0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
            r_beat     <= '0;
            r_ifg      <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (w_load_new) begin
                r_active <= i_arp_reply;
            end else if (w_promote) begin
                r_active <= r_pending;
            end
            if (w_to_pend) begin
                r_pending <= i_arp_reply;
            end
            if (w_to_pend) begin
                r_pend_vld <= 1'b1;
            end else if (w_promote) begin
                r_pend_vld <= 1'b0;
            end
            if (w_hs) begin
                r_beat <= w_last_hs ? '0 : r_beat + 1'b1;
            end
            r_ifg  <= (r_state == ST_GAP) ? r_ifg + 1'b1 : '0;
            r_drop <= w_drop;
        end
    end

    assign o_tvalid = (r_state == ST_SEND);
    assign o_tdata  = o_tvalid ? beat_of(r_active, int'(r_beat)) : '0;
    assign o_tkeep  = o_tvalid ? keep_of(int'(r_beat)) : '0;
    assign o_tlast  = o_tvalid && (r_beat == LAST_BEAT);
    assign o_busy   = (r_state != ST_IDLE) || r_pend_vld;
    assign o_drop   = r_drop;

endmodule

// File: tb/tb_ethernet_arp_reply_serializer.sv
// Bench for the ARP reply serializer: two instances (IFG 2 and IFG 0) share one stimulus stream.
module tb_ethernet_arp_reply_serializer;
    import ethernet_pkg::*;

    localparam int FB = 54;

    logic          clk = 1'b0;
    logic          rst;
    logic [FB*8-1:0] frame_in;
    logic          strb;
    logic          tready;

    logic [63:0] a_tdata, b_tdata;
    logic [7:0]  a_tkeep, b_tkeep;
    logic        a_tvalid, b_tvalid, a_tlast, b_tlast, a_busy, b_busy, a_drop, b_drop;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          c;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } hs_t;

    hs_t hs_a[$];
    hs_t hs_b[$];
    int  drop_a[$];
    int  drop_b_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ethernet_arp_reply_serializer #(.IFG_CYCLES(2)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_arp_reply(frame_in), .i_arp_reply_ready(strb),
        .o_tdata(a_tdata), .o_tkeep(a_tkeep), .o_tvalid(a_tvalid), .o_tlast(a_tlast),
        .i_tready(tready), .o_busy(a_busy), .o_drop(a_drop)
    );

    ethernet_arp_reply_serializer #(.IFG_CYCLES(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_arp_reply(frame_in), .i_arp_reply_ready(strb),
        .o_tdata(b_tdata), .o_tkeep(b_tkeep), .o_tvalid(b_tvalid), .o_tlast(b_tlast),
        .i_tready(tready), .o_busy(b_busy), .o_drop(b_drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FB*8-1:0] rand_frame();
        logic [FB*8-1:0] v;
        logic [7:0]      b;
        v = '0;
        for (int j = 0; j < FB; j++) begin
            if (j < 7)       b = 8'h55;
            else if (j == 7) b = 8'hD5;
            else             b = 8'($urandom_range(0, 255));
            v[(FB - j)*8 - 1 -: 8] = b;
        end
        return v;
    endfunction

    // Pops one frame's worth of handshakes and checks it byte-for-byte against the frame vector.
    task automatic check_frame(input logic [FB*8-1:0] f, input int sel, input string tag,
                               output int c0, output int c6);
        hs_t         h;
        logic [63:0] exp;
        int          sz;
        int          j;
        c0 = -1;
        c6 = -1;
        sz = (sel == 0) ? hs_a.size() : hs_b.size();
        chk({tag, "_nbeats"}, 64'(sz >= 7), 64'd1);
        if (sz < 7) return;
        for (int k = 0; k < 7; k++) begin
            if (sel == 0) h = hs_a.pop_front();
            else          h = hs_b.pop_front();
            exp = '0;
            for (int n = 0; n < 8; n++) begin
                j = 8*k + n;
                if (j < FB) exp[8*n +: 8] = f[(FB - j)*8 - 1 -: 8];
            end
            chk($sformatf("%s_b%0d_data", tag, k), h.d, exp);
            chk($sformatf("%s_b%0d_keep", tag, k), 64'(h.k), (k < 6) ? 64'hFF : 64'h3F);
            chk($sformatf("%s_b%0d_last", tag, k), 64'(h.l), 64'(k == 6));
            if (k == 0) c0 = h.c;
            if (k == 6) c6 = h.c;
        end
    endtask

    task automatic wait_hs(input int sel, input int n, input int bound, input string tag);
        int i;
        i = 0;
        while (((sel == 0) ? hs_a.size() : hs_b.size()) < n && i < bound) begin
            step();
            i++;
        end
        chk({tag, "_timeout"}, 64'(((sel == 0) ? hs_a.size() : hs_b.size()) >= n), 64'd1);
    endtask

    // Protocol monitor: records handshakes/drops, checks stall stability and zero-when-idle.
    logic        stall_prev = 1'b0;
    logic [63:0] prev_d;
    logic [7:0]  prev_k;
    logic        prev_l;
    always @(negedge clk) begin
        if (stall_prev) begin
            chk("stall_data", a_tdata, prev_d);
            chk("stall_ctl", 64'({a_tvalid, a_tlast, a_tkeep}), 64'({1'b1, prev_l, prev_k}));
        end
        if (a_tvalid !== 1'b1) begin
            chk("idle_zero", a_tdata | 64'({a_tlast, a_tkeep}), 64'd0);
        end
        if (a_tvalid && tready) hs_a.push_back('{cyc, a_tdata, a_tkeep, a_tlast});
        if (b_tvalid && tready) hs_b.push_back('{cyc, b_tdata, b_tkeep, b_tlast});
        if (a_drop) drop_a.push_back(cyc);
        if (b_drop) drop_b_cnt++;
        stall_prev = !rst && a_tvalid && !tready;
        prev_d = a_tdata;
        prev_k = a_tkeep;
        prev_l = a_tlast;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [FB*8-1:0] fa, fb, fc;
        int n0, c0a, c6a, c0b, c6b, nl;
        logic [3:0] pat;

        rst = 1'b1; strb = 1'b0; tready = 1'b0; frame_in = '0;
        step(); step();
        @(negedge clk);
        chk("rst_tvalid", 64'(a_tvalid), 64'd0);
        chk("rst_tdata",  a_tdata, 64'd0);
        chk("rst_tkeep",  64'(a_tkeep), 64'd0);
        chk("rst_tlast",  64'(a_tlast), 64'd0);
        chk("rst_busy",   64'(a_busy), 64'd0);
        chk("rst_drop",   64'(a_drop), 64'd0);
        chk("rst_b_tvalid", 64'(b_tvalid), 64'd0);
        step();
        rst = 1'b0;
        step();

        // 1: single frame, sink always ready
        fa = rand_frame();
        tready = 1'b1;
        frame_in = fa; strb = 1'b1; n0 = cyc;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", c), 64'(a_busy), 64'((c >= 1) && (c <= 9)));
            step();
            if (c == 0) strb = 1'b0;
        end
        chk("t1_hs_count", 64'(hs_a.size()), 64'd7);
        if (hs_a.size() > 0) chk("t1_beat0_preamble", hs_a[0].d, 64'hD555555555555555);
        check_frame(fa, 0, "t1", c0a, c6a);
        chk("t1_first_cycle", 64'(c0a), 64'(n0 + 1));
        chk("t1_last_cycle",  64'(c6a), 64'(n0 + 7));
        hs_b.delete();

        // 2: back-pressure pattern 1,0,0,1
        pat = 4'b1001;
        fa = rand_frame();
        frame_in = fa; strb = 1'b1;
        step();
        strb = 1'b0;
        for (int i = 1; i < 120 && hs_a.size() < 7; i++) begin
            tready = pat[i % 4];
            step();
        end
        tready = 1'b1;
        wait_hs(0, 7, 10, "t2");
        check_frame(fa, 0, "t2", c0a, c6a);
        chk("t2_stalled", 64'((c6a - c0a) > 6), 64'd1);
        repeat (6) step();
        hs_b.delete();

        // 3: back-to-back, second strobe during beat 3
        fa = rand_frame(); fb = rand_frame();
        frame_in = fa; strb = 1'b1; n0 = cyc;
        step(); strb = 1'b0;
        repeat (3) step();
        frame_in = fb; strb = 1'b1;
        step(); strb = 1'b0;
        wait_hs(0, 14, 40, "t3");
        check_frame(fa, 0, "t3a", c0a, c6a);
        check_frame(fb, 0, "t3b", c0b, c6b);
        chk("t3_a_start", 64'(c0a), 64'(n0 + 1));
        chk("t3_gap", 64'(c0b - c6a), 64'd3);
        chk("t3_no_drop", 64'(drop_a.size() + drop_b_cnt), 64'd0);
        repeat (6) step();
        hs_b.delete();

        // 4: overflow, third frame dropped
        fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
        frame_in = fa; strb = 1'b1; n0 = cyc;
        step(); strb = 1'b0;
        step(); frame_in = fb; strb = 1'b1;
        step(); frame_in = fc; strb = 1'b1;
        step(); strb = 1'b0;
        repeat (22) step();
        chk("t4_drop_count", 64'(drop_a.size()), 64'd1);
        if (drop_a.size() > 0) chk("t4_drop_cycle", 64'(drop_a[0]), 64'(n0 + 4));
        check_frame(fa, 0, "t4a", c0a, c6a);
        check_frame(fb, 0, "t4b", c0b, c6b);
        chk("t4_nothing_else", 64'(hs_a.size()), 64'd0);
        drop_a.delete(); drop_b_cnt = 0; hs_b.delete();

        // 5: reset at beat 4 with a pending frame
        fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
        frame_in = fa; strb = 1'b1;
        step(); frame_in = fb;
        step(); strb = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t5_tvalid", 64'(a_tvalid), 64'd0);
        chk("t5_tdata",  a_tdata, 64'd0);
        chk("t5_tkeep",  64'(a_tkeep), 64'd0);
        chk("t5_tlast",  64'(a_tlast), 64'd0);
        chk("t5_busy",   64'(a_busy), 64'd0);
        step();
        rst = 1'b0;
        repeat (15) step();
        chk("t5_abandoned_beats", 64'(hs_a.size()), 64'd5);
        nl = 0;
        foreach (hs_a[i]) nl += int'(hs_a[i].l);
        chk("t5_no_tlast", 64'(nl), 64'd0);
        hs_a.delete(); hs_b.delete(); drop_a.delete(); drop_b_cnt = 0;
        frame_in = fc; strb = 1'b1; n0 = cyc;
        step(); strb = 1'b0;
        wait_hs(0, 7, 20, "t5");
        check_frame(fc, 0, "t5c", c0a, c6a);
        chk("t5_restart_cycle", 64'(c0a), 64'(n0 + 1));
        repeat (6) step();
        hs_b.delete();

        // 6: strobe coincident with last-beat handshake, IFG 2 and IFG 0
        fa = rand_frame(); fb = rand_frame();
        frame_in = fa; strb = 1'b1; n0 = cyc;
        step(); strb = 1'b0;
        repeat (6) step();
        frame_in = fb; strb = 1'b1;
        step(); strb = 1'b0;
        wait_hs(0, 14, 40, "t6a");
        wait_hs(1, 14, 40, "t6b");
        check_frame(fa, 0, "t6a_A", c0a, c6a);
        check_frame(fb, 0, "t6a_B", c0b, c6b);
        chk("t6_ifg2_last", 64'(c6a), 64'(n0 + 7));
        chk("t6_ifg2_gap",  64'(c0b - c6a), 64'd3);
        check_frame(fa, 1, "t6b_A", c0a, c6a);
        check_frame(fb, 1, "t6b_B", c0b, c6b);
        chk("t6_ifg0_gap",  64'(c0b - c6a), 64'd1);
        chk("t6_no_drop", 64'(drop_a.size() + drop_b_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
